// File: rtl/flag_xfer_scheduler.sv
// Round-robin scheduler that shares one toggle-based flag-crossing channel
// among NREQ source-domain requesters, enforcing GAP cycles between pulses.
module flag_xfer_scheduler #(
  parameter int NREQ = 4,
  parameter int IDW  = 2,
  parameter int GAP  = 6
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            enable,
  input  logic [NREQ-1:0] req,
  input  logic            clr_overflow,
  output logic            flag_out,
  output logic [IDW-1:0]  flag_id,
  output logic [NREQ-1:0] grant,
  output logic [NREQ-1:0] pending,
  output logic            busy,
  output logic [NREQ-1:0] overflow,
  output logic            dbg_state
);

  localparam int CW = (GAP > 2) ? $clog2(GAP) : 1;
  // Counter reaches zero in the cycle before the earliest allowed next pulse.
  localparam logic [CW-1:0] CNT_LOAD = CW'(GAP - 1);

  typedef enum logic {S_IDLE, S_HOLD} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [IDW-1:0]  last;
  logic [IDW-1:0]  sel;
  logic [IDW-1:0]  hi_sel;
  logic [IDW-1:0]  lo_sel;
  logic            hi_found;
  logic            do_issue;
  logic [NREQ-1:0] iss_vec;

  // First pending index above last wins; otherwise wrap to the lowest pending.
  always_comb begin
    hi_found = 1'b0;
    hi_sel   = '0;
    lo_sel   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (pending[i] && (i > int'(last))) begin
        hi_found = 1'b1;
        hi_sel   = IDW'(i);
      end
      if (pending[i]) begin
        lo_sel = IDW'(i);
      end
    end
    sel = hi_found ? hi_sel : lo_sel;
  end

  assign do_issue  = enable && (|pending) &&
                     ((state == S_IDLE) || ((state == S_HOLD) && (cnt == '0)));
  assign iss_vec   = do_issue ? (NREQ'(1) << sel) : '0;
  assign dbg_state = (state == S_HOLD);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      last     <= IDW'(NREQ - 1);
      flag_out <= 1'b0;
      flag_id  <= '0;
      grant    <= '0;
      busy     <= 1'b0;
      pending  <= '0;
      overflow <= '0;
    end else begin
      // A request landing on its own issue cycle survives as a fresh pending bit.
      pending  <= (pending & ~iss_vec) | req;
      overflow <= (overflow & ~{NREQ{clr_overflow}}) | (req & pending & ~iss_vec);
      flag_out <= 1'b0;
      grant    <= '0;
      if (do_issue) begin
        flag_out <= 1'b1;
        grant    <= iss_vec;
        flag_id  <= sel;
        last     <= sel;
        busy     <= 1'b1;
        cnt      <= CNT_LOAD;
        state    <= S_HOLD;
      end else begin
        case (state)
          S_HOLD: begin
            if (cnt == '0) begin
              busy  <= 1'b0;
              state <= S_IDLE;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          default: begin
            busy <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/flag_xfer_scheduler.md
Name: flag_xfer_scheduler

Overview:
Single-clock scheduler that shares one pulse-synchroniser channel (toggle-based flag crossing) between NREQ requesters in the source domain. It latches single-cycle request strobes as pending bits and arbitrates them round-robin. It issues one-cycle flag pulses with a guaranteed minimum spacing, so the slower destination domain resolves every toggle. It presents a stable channel ID alongside each pulse for the destination to sample.

Parameters:
NREQ, 4, number of requesters (2..16)
IDW, 2, width of flag_id; must satisfy 2**IDW >= NREQ
GAP, 6, minimum clock cycles between successive flag_out rising edges (>= 2); sized to cover 3 destination clock edges plus margin

Ports:
clock  input  1  sole clock; all logic on rising edge
reset_n  input  1  asynchronous, active-low reset
enable  input  1  1 = scheduler may issue new pulses
req  input  NREQ  per-requester strobe; each high cycle = one request
clr_overflow  input  1  clears all overflow bits
flag_out  output  1  one-cycle pulse to the synchroniser input
flag_id  output  IDW  index of the requester served by the most recent flag_out
grant  output  NREQ  one-hot, high in the same cycle as flag_out
pending  output  NREQ  latched outstanding requests
busy  output  1  high from the flag_out cycle until the holdoff expires
overflow  output  NREQ  sticky: a request was lost (merged) for that index

Behaviour:
- Reset (async assert, sync-safe deassert by system): flag_out=0, grant=0, pending=0, overflow=0, busy=0, flag_id=0, state=IDLE, round-robin pointer last=NREQ-1 (so index 0 has highest priority first).
- Clock and reset naming: clock, reset_n; reset is asynchronous and active-low.
- Pending: req[i] high in a cycle sets pending[i] on the next edge. grant[i] clears pending[i].
- Pending, same-cycle events: if req[i] and grant[i] occur in the same cycle, pending[i] stays 1 (the new request is kept) and overflow is not set.
- Overflow: req[i] high while pending[i]=1 and grant[i]=0 sets overflow[i]. The request merges with the outstanding one.
- Overflow clear: clr_overflow clears all bits. If a set and a clear occur in the same cycle, the set wins for that bit.
- States: IDLE, HOLD.
- IDLE: if enable=1 and pending!=0, select the first pending index searching upward (modulo NREQ) from last+1. On the next edge: flag_out=1, grant[sel]=1, flag_id=sel, last=sel, busy=1, holdoff counter loaded, go to HOLD.
- HOLD: flag_out and grant return to 0 after exactly one cycle. The counter decrements each cycle. The next flag_out rising edge occurs no earlier than GAP cycles after the previous one. Exactly GAP cycles after when a request was pending and enable=1 throughout. busy falls in the cycle the holdoff expires with nothing issued; if a pulse is issued back-to-back, busy stays 1.
- Latency: a req strobe at cycle t with the scheduler IDLE and enable=1 gives flag_out at t+2 (pending registered at t+1, issue registered at t+2).
- flag_id holds its value from its flag_out cycle until the next flag_out. It never changes within GAP-1 cycles after a pulse.
- enable=0: no new issue. An in-progress HOLD completes normally. Pending and overflow keep accumulating.
- Re-enable: enable returning to 1 in IDLE allows an issue on the next edge.
- Reset mid-HOLD: outputs clear immediately; no partial pulse; the pointer returns to NREQ-1.
- Counter width: ceil(log2(GAP)) bits; no wrap in normal operation.

Test Plan:
- Single request, GAP=6: req[2] strobe at cycle 10 -> flag_out=1, grant=0100, flag_id=2 at cycle 12. busy is high 12..17 and low at 18. pending[2]=0 from 12.
- Round-robin under load: req=1111 in one cycle, then idle -> flag_out pulses every 6 cycles with flag_id sequence 0,1,2,3. Then req[0] and req[3] together -> order 0,3. Immediately after, req=1001 again -> 0,3 (the pointer wrapped).
- Overflow: req[1] strobed twice, 2 cycles apart, while HOLD serves index 0 -> overflow=0010, one grant for index 1 only. clr_overflow pulsed together with a fresh collision -> overflow stays 0010.
- Same-cycle grant and request: req[1] in the cycle grant[1]=1 -> pending[1]=1, overflow=0, second flag_out for index 1 exactly 6 cycles later.
- Enable gating: enable=0 with pending=0101 for 20 cycles -> no flag_out. Enable raised at cycle 30 -> flag_out at 31, flag_id=0.
- Async reset mid-HOLD: reset_n low 2 cycles after a pulse -> all outputs 0 within the reset cycle. After release, req[3] -> flag_id=3 at cycle release+2, and the pointer search starts from index 0.
